// File: rtl/seletor_entrada_onehot.sv
// seletor_entrada_onehot
// Push-button front end for the 7-line one-hot encoder: synchronises seven
// active-low buttons, debounces press and release, rejects multi-button
// presses and holds the accepted choice as a registered one-hot word on A..G.
// Optional feature macro: SELETOR_TOGGLE_EN (re-pressing the held button
// clears the selection instead of reloading it).
module seletor_entrada_onehot #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] btn_n,
    input  logic       clear,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       valid,
    output logic       new_sel,
    output logic       error
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [6:0]    sync1;
    logic [6:0]    sync2;
    logic [6:0]    s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [6:0]    cand;
    logic [6:0]    cand_next;
    logic [6:0]    sel;
    logic [6:0]    sel_next;
    logic          accept;
    logic          cand_single;
    logic          new_sel_next;
    logic          error_next;

    // Two-flop synchroniser; reset value is "all buttons released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    // Exactly one bit set in the candidate pattern.
    assign cand_single = (cand != '0) && ((cand & (cand - 7'd1)) == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, debounce counter and candidate capture.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (s != '0) begin
                    cand_next  = s;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s != cand) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT_RELEASE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (s != '0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: selection update, new_sel and error pulses.
    // An accepted single press takes priority over a coincident clear.
    always_comb begin
        sel_next     = sel;
        new_sel_next = 1'b0;
        error_next   = 1'b0;
        if (clear) begin
            sel_next = '0;
        end
        if (accept) begin
            if (cand_single) begin
`ifdef SELETOR_TOGGLE_EN
                if (cand == sel) begin
                    sel_next = '0;
                end else begin
                    sel_next     = cand;
                    new_sel_next = 1'b1;
                end
`else
                sel_next     = cand;
                new_sel_next = 1'b1;
`endif
            end else begin
                error_next = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cand    <= '0;
            sel     <= '0;
            new_sel <= 1'b0;
            error   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            cand    <= cand_next;
            sel     <= sel_next;
            new_sel <= new_sel_next;
            error   <= error_next;
        end
    end

    assign {G, F, E, D, C, B, A} = sel;
    assign valid = |sel;

endmodule

// File: doc/seletor_entrada_onehot.md
# seletor_entrada_onehot

Debounced push-button front end feeding the 7-line one-hot → 3-bit encoder stage.
- Samples seven raw active-low buttons, synchronises and debounces them, and rejects multi-button presses.
- Holds the accepted choice as a clean one-hot word on outputs A..G, which connect 1:1 to the encoder inputs A..G.
- Guarantees the encoder only ever sees all-zero or exactly one active line.

## Interface
- DEB_CYCLES, 16, consecutive stable cycles required to accept a press or a release; legal range 2..65535; counter width is $clog2(DEB_CYCLES).
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_n  input  7  raw buttons, active-low, asynchronous; bit 0→A … bit 6→G.
- clear  input  1  synchronous; drops the held selection.
- A,B,C,D,E,F,G  output  1 each  registered one-hot selection, to the encoder.
- valid  output  1  high while a selection is held; equals OR of A..G.
- new_sel  output  1  one-cycle pulse when a selection is loaded.
- error  output  1  one-cycle pulse when a stable multi-button press is rejected.

## Operation
- Input conditioning: btn_n passes through a two-flop synchroniser; s = ~sync (active-high pattern).
- FSM has three states.
- IDLE:
  - If s≠0: cand←s, cnt←0, go to DEBOUNCE.
- DEBOUNCE:
  - If s≠cand: return to IDLE; nothing is loaded.
  - Else if cnt==DEB_CYCLES-1: accept, then go to WAIT_RELEASE.
  - Else: cnt++.
- Accept:
  - If popcount(cand)==1: A..G←cand, new_sel=1 for one cycle.
  - If popcount(cand)≥2: selection unchanged, error=1 for one cycle.
- WAIT_RELEASE:
  - cnt counts consecutive cycles with s==0; any s≠0 resets cnt to 0.
  - When cnt reaches DEB_CYCLES-1 with s==0, go to IDLE.
  - No new press is recognised before the release is debounced.
- clear=1: A..G←0 and valid←0 at the next edge; the FSM is unaffected.
  - If clear coincides with an accept, the accept wins: the new selection is loaded and new_sel pulses.
- Reset (asynchronous, any time, including mid-debounce):
  - State←IDLE, cnt←0, cand←0, synchroniser←all-released.
  - A..G=0, valid=0, new_sel=0, error=0.
- Outputs A..G are never more than one-hot.

## Timing
- Raw press first sampled by the synchroniser at edge p, stable thereafter → A..G/valid/new_sel update at edge p+DEB_CYCLES+2.
- error has the same latency as new_sel.
- A glitch shorter than DEB_CYCLES cycles, measured at the synchroniser output, never loads.
- Release debounce takes DEB_CYCLES cycles of s==0 after entering WAIT_RELEASE. The earliest next acceptance follows from there.
- clear takes effect in 1 cycle.

## Configuration
- SELETOR_TOGGLE_EN defined:
  - An accepted single press equal to the currently held selection clears it: A..G←0, valid←0.
  - new_sel is not pulsed in that case.
- SELETOR_TOGGLE_EN undefined:
  - Re-pressing the held button reloads the same value.
  - new_sel pulses; A..G remain unchanged.

## Test plan
All scenarios use DEB_CYCLES=4.
- Reset: hold rst_n=0, btn_n=7'h7F → all outputs 0. Release reset, no presses for 20 cycles → outputs stay 0.
- Single press: btn_n=7'h7B (C) held 10 cycles → C=1, others 0, valid=1, new_sel high exactly 1 cycle, at edge p+6. Encoder downstream reads 011.
- Bounce: btn_n toggles 7'h7F/7'h7E every 2 cycles for 12 cycles, then settles at 7'h7F → no new_sel, A..G stay 0.
- Multi-press: btn_n=7'h3E (A and G) held 10 cycles → error pulses once, valid unchanged. Then press G alone after the release is debounced → G=1.
- Release gating and clear:
  - Hold D, then switch directly to E without a 4-cycle release → selection stays D.
  - Release 5 cycles, then press E → E=1.
  - Pulse clear → valid=0 the next cycle.
- Toggle: re-press the held E.
  - With SELETOR_TOGGLE_EN: A..G=0, valid=0, new_sel=0.
  - Without it: E=1, new_sel pulses.
  - Also assert rst_n=0 mid-debounce → immediate all-zero outputs and no later spurious new_sel.
